// File: rtl/player_action_ctrl.sv
// player_action_ctrl
// Per-player input/action controller placed directly before the movement stage.
// It synchronizes the raw buttons and samples them once per frame tick (SCEN).
// It runs the attack (startup/active/recovery) and hitstun state machine.
// It drives the movement-stage commands and the attack hitbox enable.
// All state and output changes happen on SCEN cycles only, so the outputs
// hold steady between frame ticks.
module player_action_ctrl #(
  parameter int STARTUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES   = 3,
  parameter int RECOVERY_FRAMES = 6,
  parameter int HITSTUN_FRAMES  = 12,
  parameter int CNT_WIDTH       = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCEN,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_attack,
  input  logic       jump_active,
  input  logic       hit,
  output logic       move_enable,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       attack_hitbox,
  output logic [2:0] state,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STARTUP  = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_RECOVERY = 3'd3,
    ST_HITSTUN  = 3'd4
  } state_e;

  // Counter reload values: each phase counts length-1 down to 0.
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO      = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] STARTUP_LOAD  = CNT_WIDTH'(STARTUP_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] ACTIVE_LOAD   = CNT_WIDTH'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] RECOVERY_LOAD = CNT_WIDTH'(RECOVERY_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] HITSTUN_LOAD  = CNT_WIDTH'(HITSTUN_FRAMES - 1);

  // Button bit order: [0]=left [1]=right [2]=jump [3]=attack
  logic [3:0] btn_raw_s;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic       sync_left_s;
  logic       sync_right_s;
  logic       sync_jump_s;
  logic       sync_attack_s;

  logic       prev_jump_q;
  logic       prev_jump_d;
  logic       prev_attack_q;
  logic       prev_attack_d;
  logic       jump_edge_s;
  logic       atk_edge_s;

  logic       hit_pending_q;
  logic       hit_pending_d;
  logic       hit_now_s;

  state_e               state_q;
  state_e               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 next_idle_s;

  logic move_enable_q;
  logic move_enable_d;
  logic move_left_q;
  logic move_left_d;
  logic move_right_q;
  logic move_right_d;
  logic jump_q;
  logic jump_d;
  logic attack_hitbox_q;
  logic attack_hitbox_d;
  logic busy_q;
  logic busy_d;

  assign btn_raw_s     = {btn_attack, btn_jump, btn_right, btn_left};
  assign sync_left_s   = sync2_q[0];
  assign sync_right_s  = sync2_q[1];
  assign sync_jump_s   = sync2_q[2];
  assign sync_attack_s = sync2_q[3];

  // Frame-to-frame rising edges of the synchronized jump/attack buttons.
  assign jump_edge_s = sync_jump_s & ~prev_jump_q;
  assign atk_edge_s  = sync_attack_s & ~prev_attack_q;

  // A hit seen on this very SCEN counts as well as one latched earlier.
  assign hit_now_s   = hit_pending_q | hit;
  assign next_idle_s = (state_d == ST_IDLE);

  // Two-flop synchronizer for the asynchronous buttons, clocked every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn_raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Next value of the per-frame button samples and the pending-hit latch.
  always_comb begin
    prev_jump_d   = prev_jump_q;
    prev_attack_d = prev_attack_q;
    hit_pending_d = hit_pending_q;
    if (SCEN) begin
      prev_jump_d   = sync_jump_s;
      prev_attack_d = sync_attack_s;
      // Any hit, latched or coincident, is consumed on this tick.
      hit_pending_d = 1'b0;
    end else begin
      hit_pending_d = hit_pending_q | hit;
    end
  end

  // Frame sample registers and pending-hit latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_jump_q   <= 1'b0;
      prev_attack_q <= 1'b0;
      hit_pending_q <= 1'b0;
    end else begin
      prev_jump_q   <= prev_jump_d;
      prev_attack_q <= prev_attack_d;
      hit_pending_q <= hit_pending_d;
    end
  end

  // FSM next-state and phase counter; hits pre-empt every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (SCEN) begin
      if (hit_now_s) begin
        state_d = ST_HITSTUN;
        cnt_d   = HITSTUN_LOAD;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Airborne attack presses are dropped, not buffered.
            if (atk_edge_s && !jump_active) begin
              state_d = ST_STARTUP;
              cnt_d   = STARTUP_LOAD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end
          end
          ST_STARTUP: begin
            if (cnt_q != CNT_ZERO) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              state_d = ST_ACTIVE;
              cnt_d   = ACTIVE_LOAD;
            end
          end
          ST_ACTIVE: begin
            if (cnt_q != CNT_ZERO) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              state_d = ST_RECOVERY;
              cnt_d   = RECOVERY_LOAD;
            end
          end
          ST_RECOVERY: begin
            if (cnt_q != CNT_ZERO) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end
          end
          ST_HITSTUN: begin
            if (cnt_q != CNT_ZERO) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        endcase
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // FSM state and phase counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output next values, derived from the next state and refreshed only on SCEN.
  always_comb begin
    move_enable_d   = move_enable_q;
    move_left_d     = move_left_q;
    move_right_d    = move_right_q;
    jump_d          = jump_q;
    attack_hitbox_d = attack_hitbox_q;
    busy_d          = busy_q;
    if (SCEN) begin
      // The jump arc keeps running even while locked out.
      move_enable_d   = next_idle_s | jump_active;
      move_left_d     = next_idle_s & sync_left_s & ~sync_right_s;
      move_right_d    = next_idle_s & sync_right_s & ~sync_left_s;
      // Attack wins over jump when both edges land in the same frame.
      jump_d          = next_idle_s & jump_edge_s & ~atk_edge_s & ~jump_active;
      attack_hitbox_d = (state_d == ST_ACTIVE);
      busy_d          = ~next_idle_s;
    end else begin
      move_enable_d   = move_enable_q;
      move_left_d     = move_left_q;
      move_right_d    = move_right_q;
      jump_d          = jump_q;
      attack_hitbox_d = attack_hitbox_q;
      busy_d          = busy_q;
    end
  end

  // Registered outputs; reset clears everything, including any live hitbox.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      move_enable_q   <= 1'b0;
      move_left_q     <= 1'b0;
      move_right_q    <= 1'b0;
      jump_q          <= 1'b0;
      attack_hitbox_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      move_enable_q   <= move_enable_d;
      move_left_q     <= move_left_d;
      move_right_q    <= move_right_d;
      jump_q          <= jump_d;
      attack_hitbox_q <= attack_hitbox_d;
      busy_q          <= busy_d;
    end
  end

  assign move_enable   = move_enable_q;
  assign move_left     = move_left_q;
  assign move_right    = move_right_q;
  assign jump          = jump_q;
  assign attack_hitbox = attack_hitbox_q;
  assign busy          = busy_q;
  assign state         = state_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Testbench for player_action_ctrl: a table of frame vectors, hand-written
// multi-cycle sequences (hit during attack, hit restart, mid-attack reset,
// hit on a tick), then random stimulus against a frame-age reference model.
module tb_player_action_ctrl;

  localparam int S_FR = 4;
  localparam int A_FR = 3;
  localparam int R_FR = 6;
  localparam int H_FR = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       SCEN;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_attack;
  logic       jump_active;
  logic       hit;
  logic       move_enable;
  logic       move_left;
  logic       move_right;
  logic       jump;
  logic       attack_hitbox;
  logic [2:0] state;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buttons seen through a two-cycle delay, and the action
  // described as (mode, frames since it started) rather than as a countdown.
  logic [3:0] m_s1 = 4'b0000;
  logic [3:0] m_s2 = 4'b0000;
  logic       m_prev_j = 1'b0;
  logic       m_prev_a = 1'b0;
  logic       m_pend = 1'b0;
  int         m_mode = 0;   // 0 none, 1 attack, 2 hitstun
  int         m_age  = 0;
  logic [8:0] m_out  = 9'd0;

  typedef struct {
    logic       l;
    logic       r;
    logic       j;
    logic       a;
    logic       ja;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[26];

  always #5 clk = ~clk;

  player_action_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .SCEN         (SCEN),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .btn_attack   (btn_attack),
    .jump_active  (jump_active),
    .hit          (hit),
    .move_enable  (move_enable),
    .move_left    (move_left),
    .move_right   (move_right),
    .jump         (jump),
    .attack_hitbox(attack_hitbox),
    .state        (state),
    .busy         (busy)
  );

  // Expected output vector: {me, left, right, jump, hitbox, busy, state}.
  function automatic logic [8:0] mk(input logic me, input logic ml, input logic mr,
                                    input logic jp, input logic hb, input int st);
    logic [2:0] s3;
    s3 = 3'(st);
    return {me, ml, mr, jp, hb, (st != 0), s3};
  endfunction

  function automatic vec_t mkv(input logic l, input logic r, input logic j, input logic a,
                               input logic ja, input logic [8:0] e);
    vec_t v;
    v.l = l; v.r = r; v.j = j; v.a = a; v.ja = ja; v.exp = e;
    return v;
  endfunction

  // Phase reported for an action that started age frames ago.
  function automatic int phase_of(input int mode, input int age);
    if (mode == 1) begin
      if (age < S_FR) return 1;
      if (age < S_FR + A_FR) return 2;
      if (age < S_FR + A_FR + R_FR) return 3;
      return 0;
    end
    if (mode == 2) begin
      if (age < H_FR) return 4;
      return 0;
    end
    return 0;
  endfunction

  // Advance the model by one clk using the inputs currently applied.
  task automatic model_clk();
    logic je, ae, idle;
    int ph;
    if (!reset_n) begin
      m_s1 = 4'b0000; m_s2 = 4'b0000;
      m_prev_j = 1'b0; m_prev_a = 1'b0; m_pend = 1'b0;
      m_mode = 0; m_age = 0; m_out = 9'd0;
    end else begin
      if (SCEN) begin
        je = m_s2[2] & ~m_prev_j;
        ae = m_s2[3] & ~m_prev_a;
        if (m_pend | hit) begin
          m_mode = 2; m_age = 0;
        end else if (m_mode != 0) begin
          m_age = m_age + 1;
          if (phase_of(m_mode, m_age) == 0) m_mode = 0;
        end else if (ae & ~jump_active) begin
          m_mode = 1; m_age = 0;
        end
        ph = phase_of(m_mode, m_age);
        idle = (ph == 0);
        m_out = mk(idle | jump_active, idle & m_s2[0] & ~m_s2[1], idle & m_s2[1] & ~m_s2[0],
                   idle & je & ~ae & ~jump_active, (ph == 2), ph);
        m_prev_j = m_s2[2];
        m_prev_a = m_s2[3];
        m_pend = 1'b0;
      end else begin
        m_pend = m_pend | hit;
      end
      m_s2 = m_s1;
      m_s1 = {btn_attack, btn_jump, btn_right, btn_left};
    end
  endtask

  // One clk with the given SCEN; hit is a one-cycle pulse.
  task automatic step(input logic scen);
    SCEN = scen;
    model_clk();
    @(posedge clk);
    #1;
    SCEN = 1'b0;
    hit  = 1'b0;
  endtask

  // Let the buttons pass the synchronizer, then issue one frame tick.
  task automatic frame();
    step(1'b0);
    step(1'b0);
    step(1'b1);
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {move_enable, move_left, move_right, jump, attack_hitbox, busy, state};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got me/l/r/j/hb/busy/state=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_btn(input logic l, input logic r, input logic j, input logic a);
    btn_left = l; btn_right = r; btn_jump = j; btn_attack = a;
  endtask

  initial begin
    // Frame-by-frame vectors from reset: {l, r, j, a, jump_active} -> outputs.
    tbl[0]  = mkv(0, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0));  // right only
    tbl[1]  = mkv(1, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0));  // both cancel
    tbl[2]  = mkv(1, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0));  // left only
    tbl[3]  = mkv(0, 0, 1, 0, 0, mk(1, 0, 0, 1, 0, 0));  // jump edge
    tbl[4]  = mkv(0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));  // jump held
    tbl[5]  = mkv(0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));
    tbl[6]  = mkv(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0));  // released
    tbl[7]  = mkv(0, 0, 1, 1, 0, mk(0, 0, 0, 0, 0, 1));  // jump+attack: attack wins
    tbl[8]  = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1));
    tbl[9]  = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1));
    tbl[10] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1));
    tbl[11] = mkv(0, 1, 0, 0, 0, mk(0, 0, 0, 0, 1, 2));  // k+4 active, right ignored
    tbl[12] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 2));
    tbl[13] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 2));
    tbl[14] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 3));  // k+7 recovery
    tbl[15] = mkv(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 3));
    tbl[16] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 3));
    tbl[17] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 3));
    tbl[18] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 3));
    tbl[19] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 3));
    tbl[20] = mkv(0, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0));  // k+13 idle
    tbl[21] = mkv(0, 0, 0, 1, 1, mk(1, 0, 0, 0, 0, 0));  // airborne attack dropped
    tbl[22] = mkv(0, 0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0));  // landed: not replayed
    tbl[23] = mkv(0, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0));
    tbl[24] = mkv(0, 0, 1, 0, 1, mk(1, 0, 0, 0, 0, 0));  // airborne jump edge
    tbl[25] = mkv(0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));  // held: no new edge

    reset_n = 1'b0; SCEN = 1'b0; hit = 1'b0; jump_active = 1'b0;
    set_btn(0, 0, 0, 0);
    #1;
    step(1'b0);
    step(1'b0);
    check("reset", 9'd0);
    reset_n = 1'b1;
    step(1'b0);
    check("reset_hold_no_scen", 9'd0);

    for (int i = 0; i < 26; i++) begin
      set_btn(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].a);
      jump_active = tbl[i].ja;
      frame();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Hit pulse between ticks during ACTIVE, then a second hit 5 frames later.
    set_btn(0, 0, 0, 0); jump_active = 1'b0;
    frame();
    set_btn(0, 0, 0, 1);
    frame();
    check("atkA_start", mk(0, 0, 0, 0, 0, 1));
    set_btn(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) frame();
    check("atkA_active", mk(0, 0, 0, 0, 1, 2));
    step(1'b0);
    hit = 1'b1;
    step(1'b0);
    jump_active = 1'b1;
    step(1'b1);
    check("hit_in_active", mk(1, 0, 0, 0, 0, 4));
    jump_active = 1'b0;
    for (int i = 1; i <= 4; i++) frame();
    check("hit1_count", mk(0, 0, 0, 0, 0, 4));
    step(1'b0);
    hit = 1'b1;
    step(1'b0);
    step(1'b1);
    check("hit2_taken", mk(0, 0, 0, 0, 0, 4));
    for (int i = 1; i <= 12; i++) begin
      frame();
      if (i == 11) check("hit2_hold", mk(0, 0, 0, 0, 0, 4));
      if (i == 12) check("hit2_release", mk(1, 0, 0, 0, 0, 0));
    end

    // Reset for one clk during ACTIVE aborts the attack at once.
    set_btn(0, 0, 0, 1);
    frame();
    set_btn(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) frame();
    check("atkB_active", mk(0, 0, 0, 0, 1, 2));
    reset_n = 1'b0;
    step(1'b0);
    check("rst_mid_active", 9'd0);
    reset_n = 1'b1;
    frame();
    check("rst_recover", mk(1, 0, 0, 0, 0, 0));

    // Hit coincident with a tick: consumed at once, nothing left pending.
    hit = 1'b1;
    step(1'b1);
    check("hit_on_scen", mk(0, 0, 0, 0, 0, 4));
    for (int i = 1; i <= 12; i++) begin
      frame();
      if (i == 11) check("hitc_hold", mk(0, 0, 0, 0, 0, 4));
      if (i == 12) check("hitc_release", mk(1, 0, 0, 0, 0, 0));
    end

    // Random stimulus against the reference model, checked every clk.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_left    = ~btn_left;
      if ($urandom_range(0, 7) == 0) btn_right   = ~btn_right;
      if ($urandom_range(0, 9) == 0) btn_jump    = ~btn_jump;
      if ($urandom_range(0, 9) == 0) btn_attack  = ~btn_attack;
      if ($urandom_range(0, 15) == 0) jump_active = ~jump_active;
      hit     = ($urandom_range(0, 59) == 0);
      reset_n = ($urandom_range(0, 599) != 0);
      step($urandom_range(0, 2) == 0);
      check("rand", m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
